// File: rtl/product_accumulator.sv
// Batch accumulator for multiplier products: sums COUNT beats, presents the sum on a held handshake.
// Optional PRODUCT_ACCUMULATOR_SAT_EN clamps the accumulator on carry instead of wrapping.
module product_accumulator #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned ACC_W = 8,
  parameter int unsigned COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  prod_in,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             busy,
  output logic             overflow,
  output logic [7:0]       beat_cnt
);

  localparam int unsigned SumW      = ACC_W + 1;
  localparam logic [7:0]  CountLast = 8'(COUNT);
  localparam bit          SingleBeat = (COUNT == 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           state;
  logic [ACC_W-1:0] acc;
  logic             beat;
  logic [SumW-1:0]  sum_ext;
  logic             carry;
  logic [ACC_W-1:0] first_val;
  logic [ACC_W-1:0] acc_next;
  logic [7:0]       cnt_next;

  assign prod_ready = (state != StDone);
  assign busy       = (state == StAccum);
  assign beat       = prod_valid & prod_ready;

  // Zero-extend both operands so the carry out of ACC_W is observable.
  assign sum_ext   = {1'b0, acc} + SumW'(prod_in);
  assign carry     = sum_ext[ACC_W];
  assign first_val = ACC_W'(prod_in);
  assign cnt_next  = beat_cnt + 8'd1;

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
  assign acc_next = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_next = sum_ext[ACC_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      acc       <= '0;
      beat_cnt  <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (clear) begin
      // sum_out deliberately keeps the last delivered value; only sum_valid qualifies it.
      state     <= StIdle;
      acc       <= '0;
      beat_cnt  <= '0;
      sum_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (beat) begin
            acc      <= first_val;
            beat_cnt <= 8'd1;
            overflow <= 1'b0;
            if (SingleBeat) begin
              state     <= StDone;
              sum_out   <= first_val;
              sum_valid <= 1'b1;
            end else begin
              state <= StAccum;
            end
          end
        end
        StAccum: begin
          if (beat) begin
            acc      <= acc_next;
            beat_cnt <= cnt_next;
            if (carry) overflow <= 1'b1;
            if (cnt_next == CountLast) begin
              state     <= StDone;
              sum_out   <= acc_next;
              sum_valid <= 1'b1;
            end
          end
        end
        StDone: begin
          if (sum_ready) begin
            state     <= StIdle;
            sum_valid <= 1'b0;
            acc       <= '0;
            beat_cnt  <= '0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 2x2 multiplier's 4-bit product.
- Accepts products over a valid/ready handshake and sums a fixed batch of COUNT products.
- Presents the batch sum on a held output handshake, plus a sticky overflow flag.
- Sits between the multiplier output and the display/readout logic.

Parameters:
- IN_W, 4: product input width; matches the multiplier output.
- ACC_W, 8: accumulator and sum_out width.
- COUNT, 4: products per batch; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- prod_in  input  IN_W  product from multiplier, unsigned
- prod_valid  input  1  prod_in valid
- prod_ready  output  1  block can accept a product
- clear  input  1  synchronous batch abort
- sum_out  output  ACC_W  batch sum
- sum_valid  output  1  sum_out valid
- sum_ready  input  1  consumer accepts sum_out
- busy  output  1  batch in progress (state ACCUM)
- overflow  output  1  sticky; batch sum exceeded ACC_W bits
- beat_cnt  output  8  products accepted in current batch

Behaviour:
- Reset (rst=1, async, immediate): state=IDLE; acc=0; beat_cnt=0; sum_out=0; sum_valid=0; overflow=0; busy=0.
- Beat: rising edge with prod_valid=1 and prod_ready=1.
- prod_ready is combinational: 1 in IDLE and ACCUM, 0 in DONE. It does not depend on prod_valid.
- IDLE:
  - acc=0, beat_cnt=0.
  - On beat: acc=prod_in, beat_cnt=1, overflow=0.
  - Next state is ACCUM, or DONE if COUNT=1.
- ACCUM:
  - On beat: acc=acc+prod_in (zero-extended to ACC_W+1 for the add); beat_cnt++.
  - Carry out of ACC_W sets overflow. Without SAT_EN the result wraps (acc = low ACC_W bits).
  - When the beat makes beat_cnt==COUNT: next state DONE.
  - No beat: hold all state.
- DONE:
  - sum_out=acc; sum_valid=1 starting the cycle after the final beat (latency 1 from the last beat).
  - sum_out and overflow stay stable while sum_valid=1 and sum_ready=0.
  - On sum_valid and sum_ready: sum_valid=0, acc=0, beat_cnt=0, state=IDLE. prod_ready rises the next cycle.
  - overflow persists until the next batch's first beat, or clear/rst.
- clear (sync; priority: rst > clear > beat):
  - Next edge: state=IDLE, acc=0, beat_cnt=0, sum_valid=0, overflow=0.
  - A beat presented in the same cycle is discarded. Upstream must treat it as consumed.
  - clear in DONE drops the pending sum.
- Reset mid-batch: all partial state lost; outputs return to reset values immediately.
- Zero products are legal beats and count toward COUNT.
- sum_out holds the last delivered sum in IDLE/ACCUM until the next DONE. Only sum_valid qualifies it.

Optional Feature:
- Macro: PRODUCT_ACCUMULATOR_SAT_EN.
- Defined: on carry out of ACC_W, acc clamps to 2^ACC_W-1 and stays there for the rest of the batch. overflow is still set.
- Undefined: modulo 2^ACC_W wrap; overflow set on any carry.
- Handshake, latency and all other behaviour are identical either way.

Test Plan:
- Defaults; beats 9,9,9,9 back-to-back from IDLE -> sum_valid=1 one cycle after the 4th beat; sum_out=36; overflow=0; prod_ready=0 while in DONE.
- ACC_W=5, COUNT=4, beats 9,9,9,9:
  - without SAT_EN -> sum_out=4, overflow=1.
  - with PRODUCT_ACCUMULATOR_SAT_EN -> sum_out=31, overflow=1.
- Backpressure: complete a batch of 1,2,3,4 with sum_ready=0 for 3 cycles -> sum_out=10 and sum_valid stable, prod_ready=0 throughout. sum_ready=1 -> IDLE next cycle, prod_ready=1.
- Gaps: prod_valid toggled 1,0,0,1,1,0,1 with prod_in=3 -> sum_out=12 only after the 4th beat; beat_cnt steps 1,1,1,2,3,3,4.
- clear after 2 beats (4,6), with prod_valid=1 and prod_in=9 in the clear cycle -> beat_cnt=0, acc discarded, no sum_valid. A following batch 1,1,1,1 -> sum_out=4.
- rst pulsed asynchronously mid-cycle after 3 beats -> all outputs zero before the next clk edge; the next batch of 2,2,2,2 -> sum_out=8.
